dlfloat_div: RTL and testbench
==============================

Name: dlfloat_div

Overview:
- Sequential divider for 16-bit DLFloat operands: 1 sign bit, 6 exponent bits with bias 31, 9 fraction bits with a hidden leading one.
- Inverse operation to the team's combinational DLFloat multiplier. Shares its field layout and result packing {sign, exponent, fraction}.
- Quotient is computed by an iterative restoring divider, one bit per cycle.
- valid/ready handshake on input and output. One operation in flight at a time. Fixed latency.

Parameters:
- EXP_W, 6, exponent field width.
- FRAC_W, 9, stored fraction width. Iteration count is FRAC_W+3.
- BIAS, 31, exponent bias.
- Only the defaults are verified.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- flp_a  in  16  dividend.
- flp_b  in  16  divisor.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- quot  out  16  result {sign, exponent, fraction}.
- flags  out  4  {invalid, div_by_zero, overflow, underflow}.

Behaviour:
- Encodings:
  - Zero: exponent = 0, any fraction. Input fraction ignored; output zero is {sign, 15'b0}.
  - Special (Inf/NaN, single encoding): exponent = 63 and fraction = 511.
  - All other values are normal: significand m = {1, frac}, 10 bits.
- Reset values: in_ready=0 while rst_n low, 1 in IDLE after release. out_valid=0, quot=0, flags=0. FSM goes to IDLE. Reset mid-operation discards all work; no output for that operation.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture operands, sign = a[15]^b[15], remainder r = ma, counter = 0; go to DIVIDE.
  - DIVIDE: 12 cycles. Each cycle: if r >= mb then r -= mb and q bit = 1, else q bit = 0. Shift q left with the new bit; r <<= 1. Counter 11 goes to ROUND.
  - ROUND: normalize, round, pack, resolve specials; go to DONE.
  - DONE: out_valid=1; quot and flags stable. On out_ready, go to IDLE. out_valid stays high with no timeout until out_ready.
- Latency: out_valid is high 13 cycles after the accept edge. in_ready=0 outside IDLE, so a new accept is possible no earlier than the cycle after the output handshake.
- Exponent arithmetic: e = ea - eb + BIAS, computed signed 9-bit.
- Normalization:
  - If q[11]=1: significand = q[11:2], round bit = q[1], sticky = q[0] | (r != 0).
  - Else: significand = q[10:1], round bit = q[0], sticky = (r != 0), and e -= 1.
- Rounding: round-to-nearest-even. Increment when round bit = 1 and (sticky | significand[0]). A carry out to 1024 sets the significand to 512 and e += 1.
- Range checks:
  - e >= 63 after rounding: quot = {sign, 15'h7FFF}, overflow=1.
  - e <= 0: quot = {sign, 15'b0}, underflow=1. No subnormals.
- Special cases override the arithmetic but keep the same latency:
  - a=0, b=0: quot = 16'h7FFF, invalid=1.
  - a or b special: quot = 16'h7FFF, invalid=1.
  - b=0, a normal: quot = {sign, 15'h7FFF}, div_by_zero=1.
  - a=0, b normal: quot = {sign, 15'b0}, no flag.
- flags are valid only while out_valid=1.

Decomposition:
- Shared package dlfloat_pkg holds:
  - EXP_W, FRAC_W, BIAS.
  - Special-encoding constant.
  - Field-extract helpers.
  - Flag bit indices.
  - Same package to be adopted by the multiplier.
- Sub-module dlfloat_round_pack, combinational: {sign, e, q, r != 0} in, {quot, overflow, underflow} out. Reusable by a future sequential multiplier.

Test Plan:
- 0x4300 / 0x4000 (6.0 / 2.0) with out_ready=1 -> quot=0x4100, flags=0, out_valid exactly 13 cycles after accept, one output cycle.
- 0x3E00 / 0x4100 (1.0 / 3.0) -> quot=0x3AAB; exercises round-up with the normalize shift.
- 0xBE00 / 0x4000 (-1.0 / 2.0) -> quot=0xBC00. Then 0x3E00 / 0x0000 -> quot=0x7FFF, flags=4'b0100.
- Exponent 62 / exponent 1, e.g. 0x7C00 / 0x0200 -> quot=0x7FFF, overflow=1. Exponent 1 / exponent 62, 0x0200 / 0x7C00 -> quot=0x0000, underflow=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid. Required: quot/flags stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> next cycle IDLE, in_ready=1.
- rst_n pulsed low in the 6th DIVIDE cycle -> out_valid stays 0. After release, 0x3E00 / 0x3E00 gives quot=0x3E00 with normal latency.

Source files
------------

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 layout (1 sign, 6 exponent bias 31, 9 fraction), flag indices and field helpers.
// Used by the divider today and intended for the multiplier as well.
package dlfloat_pkg;
  localparam int EXP_W    = 6;
  localparam int FRAC_W   = 9;
  localparam int BIAS     = 31;
  localparam int FLT_W    = 1 + EXP_W + FRAC_W;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int QUO_W    = FRAC_W + 3;
  localparam int E_CALC_W = EXP_W + 3;

  // Inf/NaN share one encoding: all-ones exponent and fraction.
  localparam logic [FLT_W-2:0] SPECIAL_MAG = '1;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_DIVIDE, ST_ROUND, ST_DONE} div_state_t;

  function automatic logic f_sign(input logic [FLT_W-1:0] x);
    return x[FLT_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [FLT_W-1:0] x);
    return x[FLT_W-2 -: EXP_W];
  endfunction

  function automatic logic [FRAC_W-1:0] f_frac(input logic [FLT_W-1:0] x);
    return x[FRAC_W-1:0];
  endfunction

  function automatic logic [SIG_W-1:0] f_sig(input logic [FLT_W-1:0] x);
    return {1'b1, f_frac(x)};
  endfunction

  function automatic logic signed [E_CALC_W-1:0] f_exp_ext(input logic [FLT_W-1:0] x);
    return $signed({{(E_CALC_W-EXP_W){1'b0}}, f_exp(x)});
  endfunction

  function automatic logic f_is_zero(input logic [FLT_W-1:0] x);
    return f_exp(x) == '0;
  endfunction

  function automatic logic f_is_special(input logic [FLT_W-1:0] x);
    return x[FLT_W-2:0] == SPECIAL_MAG;
  endfunction
endpackage

// File: rtl/dlfloat_round_pack.sv
// Normalizes a 12-bit quotient, rounds to nearest-even and packs a DLFloat16 with range checks.
module dlfloat_round_pack
  import dlfloat_pkg::*;
(
  input  logic                       sign,
  input  logic signed [E_CALC_W-1:0] exp_in,
  input  logic [QUO_W-1:0]           q,
  input  logic                       rem_nz,
  output logic [FLT_W-1:0]           quot,
  output logic                       overflow,
  output logic                       underflow
);
  localparam logic signed [E_CALC_W-1:0] E_TOP = E_CALC_W'((1 << EXP_W) - 1);

  // Rounds only the stored fraction; a carry out means the significand reached 2.0.
  function automatic logic [FRAC_W:0] round_rne(input logic [FRAC_W-1:0] frac,
                                                input logic rnd, input logic sticky);
    return {1'b0, frac} + {{FRAC_W{1'b0}}, rnd & (sticky | frac[0])};
  endfunction

  logic [FRAC_W-1:0]           frac;
  logic                        rnd;
  logic                        sticky;
  logic signed [E_CALC_W-1:0]  e_n;
  logic signed [E_CALC_W-1:0]  e_r;
  logic [FRAC_W:0]             rsum;

  always_comb begin
    frac      = q[QUO_W-2:2];
    rnd       = q[1];
    sticky    = q[0] | rem_nz;
    e_n       = exp_in;
    if (!q[QUO_W-1]) begin
      frac   = q[QUO_W-3:1];
      rnd    = q[0];
      sticky = rem_nz;
      e_n    = exp_in - E_CALC_W'(1);
    end
    rsum      = round_rne(frac, rnd, sticky);
    e_r       = rsum[FRAC_W] ? e_n + E_CALC_W'(1) : e_n;
    quot      = {sign, e_r[EXP_W-1:0], rsum[FRAC_W-1:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (!e_r[E_CALC_W-1] && (e_r >= E_TOP)) begin
      quot     = {sign, SPECIAL_MAG};
      overflow = 1'b1;
    end else if (e_r[E_CALC_W-1] || (e_r == '0)) begin
      quot      = {sign, {(FLT_W-1){1'b0}}};
      underflow = 1'b1;
    end
  end
endmodule

// File: rtl/dlfloat_div.sv
// Sequential DLFloat16 divider: restoring division, one quotient bit per cycle, fixed latency
// of 13 cycles from accept to out_valid, one operation in flight.
module dlfloat_div
  import dlfloat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLT_W-1:0] flp_a,
  input  logic [FLT_W-1:0] flp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLT_W-1:0] quot,
  output logic [3:0]       flags
);
  div_state_t                 state, state_nxt;
  logic [3:0]                 cnt;
  logic [FLT_W-1:0]           a_q, b_q;
  logic [SIG_W:0]             rem;
  logic [SIG_W:0]             rem_sub;
  logic                       rem_ge;
  logic [QUO_W-1:0]           q_acc;
  logic                       accept;
  logic                       sign;
  logic signed [E_CALC_W-1:0] e_raw;
  logic [FLT_W-1:0]           rp_quot;
  logic                       rp_ovf, rp_unf;
  logic [FLT_W-1:0]           res_quot;
  logic [3:0]                 res_flags;

  assign in_ready  = (state == ST_IDLE) & rst_n;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;

  assign sign    = f_sign(a_q) ^ f_sign(b_q);
  assign e_raw   = f_exp_ext(a_q) - f_exp_ext(b_q) + E_CALC_W'(BIAS);
  assign rem_ge  = rem >= {1'b0, f_sig(b_q)};
  assign rem_sub = rem_ge ? rem - {1'b0, f_sig(b_q)} : rem;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (cnt == 4'(QUO_W-1)) state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      quot  <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_DIVIDE) ? cnt + 4'd1 : 4'd0;
      if (state == ST_ROUND) begin
        quot  <= res_quot;
        flags <= res_flags;
      end
    end
  end

  // Divide datapath: operands captured on accept, one restoring step per DIVIDE cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= flp_a;
      b_q   <= flp_b;
      rem   <= {1'b0, f_sig(flp_a)};
      q_acc <= '0;
    end else if (state == ST_DIVIDE) begin
      rem   <= rem_sub << 1;
      q_acc <= {q_acc[QUO_W-2:0], rem_ge};
    end
  end

  dlfloat_round_pack u_round_pack (
    .sign      (sign),
    .exp_in    (e_raw),
    .q         (q_acc),
    .rem_nz    (|rem),
    .quot      (rp_quot),
    .overflow  (rp_ovf),
    .underflow (rp_unf)
  );

  // Special operands override the arithmetic result but share its timing.
  always_comb begin
    res_quot                  = rp_quot;
    res_flags                 = '0;
    res_flags[FLAG_OVERFLOW]  = rp_ovf;
    res_flags[FLAG_UNDERFLOW] = rp_unf;
    if ((f_is_zero(a_q) && f_is_zero(b_q)) || f_is_special(a_q) || f_is_special(b_q)) begin
      res_quot                = {1'b0, SPECIAL_MAG};
      res_flags               = '0;
      res_flags[FLAG_INVALID] = 1'b1;
    end else if (f_is_zero(b_q)) begin
      res_quot                 = {sign, SPECIAL_MAG};
      res_flags                = '0;
      res_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (f_is_zero(a_q)) begin
      res_quot  = {sign, {(FLT_W-1){1'b0}}};
      res_flags = '0;
    end
  end
endmodule

// File: tb/tb_dlfloat_div.sv
// Self-checking bench for dlfloat_div: directed cases, backpressure, mid-operation reset and
// randomized operands against an exact-arithmetic reference model.
module tb_dlfloat_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] flp_a = '0;
  logic [15:0] flp_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dlfloat_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact quotient ma/mb scaled into [1,2), rounded to nearest-even on the true remainder.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [3:0] f);
    int ea, eb, ma, mb, e, num, sig, rem;
    logic s, a_zero, b_zero, a_spec, b_spec;
    s      = a[15] ^ b[15];
    ea     = int'(a[14:9]);
    eb     = int'(b[14:9]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_spec = (a[14:0] == 15'h7FFF);
    b_spec = (b[14:0] == 15'h7FFF);
    if ((a_zero && b_zero) || a_spec || b_spec) begin
      q = 16'h7FFF; f = 4'b1000;
    end else if (b_zero) begin
      q = {s, 15'h7FFF}; f = 4'b0100;
    end else if (a_zero) begin
      q = {s, 15'h0000}; f = 4'b0000;
    end else begin
      ma = 512 + int'(a[8:0]);
      mb = 512 + int'(b[8:0]);
      e  = ea - eb + 31;
      if (ma >= mb) num = ma * 512;
      else begin
        num = ma * 1024;
        e   = e - 1;
      end
      sig = num / mb;
      rem = num % mb;
      if ((2 * rem > mb) || ((2 * rem == mb) && (sig % 2 == 1))) sig++;
      if (sig == 1024) begin
        sig = 512;
        e   = e + 1;
      end
      if (e >= 63) begin
        q = {s, 15'h7FFF}; f = 4'b0010;
      end else if (e <= 0) begin
        q = {s, 15'h0000}; f = 4'b0001;
      end else begin
        q = {s, 6'(e), 9'(sig - 512)}; f = 4'b0000;
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_q, input logic [3:0] exp_f);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    flp_a     = a;
    flp_b     = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd13);
    check({tag, "_quot"}, 32'(quot), 32'(exp_q));
    check({tag, "_flags"}, 32'(flags), 32'(exp_f));
    @(negedge clk);
    check({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, eq;
    logic [3:0]  ef;
    int          bad;
    int          seen;
    int          w;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op("six_div_two", 16'h4300, 16'h4000, 16'h4100, 4'b0000);
    run_op("one_div_three", 16'h3E00, 16'h4100, 16'h3AAB, 4'b0000);
    run_op("neg_one_div_two", 16'hBE00, 16'h4000, 16'hBC00, 4'b0000);
    run_op("div_by_zero", 16'h3E00, 16'h0000, 16'h7FFF, 4'b0100);
    run_op("overflow", 16'h7C00, 16'h0200, 16'h7FFF, 4'b0010);
    run_op("underflow", 16'h0200, 16'h7C00, 16'h0000, 4'b0001);
    run_op("zero_div_zero", 16'h0000, 16'h8000, 16'h7FFF, 4'b1000);
    run_op("special_div", 16'h7FFF, 16'h3E00, 16'h7FFF, 4'b1000);
    run_op("zero_div_neg", 16'h0123, 16'hC000, 16'h8000, 4'b0000);

    // Backpressure: result must hold and no new operands may enter.
    flp_a     = 16'h4300;
    flp_b     = 16'h4000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    flp_a    = 16'h3E00;
    flp_b    = 16'h4100;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || quot !== 16'h4100 || flags !== 4'b0000 || in_ready) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_stray_result", 32'(seen), 32'd0);

    // Reset pulsed in the 6th divide cycle discards the operation.
    flp_a    = 16'h4300;
    flp_b    = 16'h4100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrst_quot", 32'(quot), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    run_op("after_reset", 16'h3E00, 16'h3E00, 16'h3E00, 4'b0000);

    // Randomized operands, occasionally zero or special.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 2; k++) begin
        int kind;
        logic [15:0] v;
        kind = $urandom_range(0, 11);
        v    = 16'($urandom);
        if (kind == 0) v[14:9] = 6'd0;
        else if (kind == 1) v[14:0] = 15'h7FFF;
        else if (kind < 6) v[14:9] = 6'($urandom_range(1, 62));
        else v[14:9] = 6'($urandom_range(20, 42));
        if (k == 0) ra = v;
        else rb = v;
      end
      ref_div(ra, rb, eq, ef);
      run_op($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, eq, ef);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
